// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer and its adder.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_LOAD,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } md_state_e;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  localparam int unsigned MD_ITER = 32;

endpackage

// File: rtl/muldiv_addsub.sv
// Add/subtract unit shared by the shift-add and restoring-subtract iterations.
module muldiv_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         sign_o
);

  always_comb begin
    sum_o = sub_i ? (x_i - y_i) : (x_i + y_i);
  end

  // Carry out for add, borrow for subtract.
  assign sign_o = sum_o[W-1];

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed mult/div producing HI/LO.
// MULDIV_DIVZERO_EXC_EN: divide-by-zero shortcut from LOAD to DONE with div_zero flag.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hi_lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic               op_q, sdiff_q, sa_q;
  logic [WIDTH-1:0]   a_q, b_q, mag_b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod_neg;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     add_x, add_y, add_sum;
  logic               add_sub, add_sign;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               busy_q, busy_d, done_q, done_d, we_q, we_d, dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .x_i   (add_x),
    .y_i   (add_y),
    .sub_i (add_sub),
    .sum_o (add_sum),
    .sign_o(add_sign)
  );

  // Div trials against the left-shifted remainder; mult adds into the unshifted high half.
  always_comb begin
    add_y = {1'b0, mag_b_q};
    if (op_q == MD_OP_DIV) begin
      add_x   = {1'b0, acc_q[2*WIDTH-2:WIDTH-1]};
      add_sub = 1'b1;
      acc_d   = add_sign ? {acc_q[2*WIDTH-2:0], 1'b0}
                         : {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      add_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_sub = 1'b0;
      acc_d   = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_neg = -acc_q;
    if (op_q == MD_OP_DIV) begin
      fix_lo = sdiff_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      fix_hi = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      {fix_hi, fix_lo} = sdiff_q ? prod_neg : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= MD_OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sdiff_q <= 1'b0;
      sa_q    <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        MD_LOAD: begin
          mag_b_q <= b_q[WIDTH-1] ? -b_q : b_q;
          acc_q   <= {{WIDTH{1'b0}}, (a_q[WIDTH-1] ? -a_q : a_q)};
          cnt_q   <= '0;
          sdiff_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          sa_q    <= a_q[WIDTH-1];
        end
        MD_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start) state_d = MD_LOAD;
      MD_LOAD: begin
        state_d = MD_RUN;
`ifdef MULDIV_DIVZERO_EXC_EN
        if (op_q == MD_OP_DIV && b_q == '0) state_d = MD_DONE;
`endif
      end
      MD_RUN:  if (cnt_q == LAST) state_d = MD_FIX;
      MD_FIX:  state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (abort && state_q != MD_IDLE) state_d = MD_IDLE;
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d != MD_IDLE);
    done_d = (state_d == MD_DONE);
`ifdef MULDIV_DIVZERO_EXC_EN
    dz_d   = done_d && (state_q == MD_LOAD);
`else
    dz_d   = 1'b0;
`endif
    we_d   = done_d && !dz_d;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (state_q == MD_FIX && state_d == MD_DONE) begin
      hi_d = fix_hi;
      lo_d = fix_lo;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi_lo_we = we_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed mult/div vectors, abort, reset and busy-start cases.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, hi_lo_we, div_zero;
  logic [W-1:0] hi, lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .hi_lo_we(hi_lo_we),
    .hi      (hi),
    .lo      (lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         we;
    logic         dz;
    int           t0;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  logic         prev_we = 1'b0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

`ifdef MULDIV_DIVZERO_EXC_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("hi_lo_we", hi_lo_we, e.we);
        chk("div_zero", div_zero, e.dz);
      end
    end else if (hi_lo_we) begin
      chk("we_without_done", hi_lo_we, 64'd0);
    end
    if (prev_we) chk("we_pulse", hi_lo_we, 64'd0);
    prev_we = hi_lo_we;
  end

  task automatic issue(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input bit push);
    exp_t e;
    bit   dz;
    @(negedge clk);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      dz    = DZ_EN && (o == MD_OP_DIV) && (bv == '0);
      e.t0  = cyc;
      e.lat = dz ? 2 : 35;
      e.dz  = dz;
      e.we  = !dz;
      e.hi  = dz ? last_hi : eh;
      e.lo  = dz ? last_lo : el;
      if (!dz) begin
        last_hi = eh;
        last_lo = el;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle", busy, 64'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 64'd0);
    chk({tag, "_done"}, done, 64'd0);
    chk({tag, "_we"}, hi_lo_we, 64'd0);
    chk({tag, "_hi"}, hi, 64'd0);
    chk({tag, "_lo"}, lo, 64'd0);
    chk({tag, "_dz"}, div_zero, 64'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b1;

    // 7 * -3 = -21
    issue(MD_OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    repeat (10) @(negedge clk);
    chk("busy_run", busy, 64'd1);
    wait_idle();

    issue(MD_OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
    wait_idle();
    issue(MD_OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1);
    wait_idle();
    issue(MD_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b1);
    wait_idle();
    issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    wait_idle();
    issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);
    wait_idle();
    issue(MD_OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_idle();
    issue(MD_OP_DIV, 32'd7, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFE, 1'b1);
    wait_idle();

    // Divide by zero: full-sequence results unless the shortcut is built in.
    issue(MD_OP_DIV, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    issue(MD_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h0000_0001, 1'b1);
    wait_idle();

    // Abort during RUN iteration 10.
    issue(MD_OP_MULT, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0);
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 64'd0);
    chk("abort_hi", hi, last_hi);
    chk("abort_lo", lo, last_lo);
    repeat (40) @(negedge clk);
    issue(MD_OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);
    wait_idle();

    // Second start while busy must be ignored.
    d0 = done_cnt;
    issue(MD_OP_MULT, 32'd1234, 32'd1000, 32'd0, 32'd1234000, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("single_done", 64'(done_cnt - d0), 64'd1);

    // Reset mid-operation.
    issue(MD_OP_DIV, 32'd50, 32'd3, 32'd2, 32'd16, 1'b1);
    repeat (18) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_zero_outputs("midreset");
    reset   = 1'b1;
    last_hi = '0;
    last_lo = '0;
    repeat (45) @(negedge clk);
    chk("midreset_idle", busy, 64'd0);

    issue(MD_OP_DIV, 32'd50, 32'd3, 32'd2, 32'd16, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
